cfg_space_mf: RTL and testbench

Multi-function PCIe Type-0 configuration space for the transaction layer: holds one header plus a scratch region per function, enforces per-bit access types (RO, RW, RW1C), and supports BAR0 sizing. It takes decoded CfgRd/CfgWr requests on a valid/ready interface. It returns one completion per request through a single-entry registered output buffer. It also exports the live Command-register enables to the rest of the TL.

---
 rtl/cfg_space_mf_if.sv | 41 ++++
 rtl/cfg_space_mf.sv | 183 ++++++++++++++++++
 tb/tb_cfg_space_mf.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_space_mf_if.sv
// -----------------------------------------------------------------------------
// cfg_space_mf_if
//   Request/completion channel between the TL decoder and cfg_space_mf.
//   master : the TL side, which issues CfgRd/CfgWr and drains completions.
//   slave  : the configuration space itself.
//   Signals:
//     req_valid/req_ready   request handshake
//     req_wr                1 = CfgWr, 0 = CfgRd
//     req_func              target function
//     req_addr_dw           DWORD offset within the function
//     req_wdata/req_be      write data and byte enables
//     cpl_valid/cpl_ready   completion handshake
//     cpl_rdata/cpl_status  read data and status (00 = SC, 01 = UR)
// -----------------------------------------------------------------------------
interface cfg_space_mf_if #(
  parameter int NUM_FUNC = 1
);
  localparam int FW = (NUM_FUNC > 1) ? $clog2(NUM_FUNC) : 1;

  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [FW-1:0] req_func;
  logic [9:0]    req_addr_dw;
  logic [31:0]   req_wdata;
  logic [3:0]    req_be;
  logic          cpl_valid;
  logic          cpl_ready;
  logic [31:0]   cpl_rdata;
  logic [1:0]    cpl_status;

  modport master (
    output req_valid, req_wr, req_func, req_addr_dw, req_wdata, req_be, cpl_ready,
    input  req_ready, cpl_valid, cpl_rdata, cpl_status
  );

  modport slave (
    input  req_valid, req_wr, req_func, req_addr_dw, req_wdata, req_be, cpl_ready,
    output req_ready, cpl_valid, cpl_rdata, cpl_status
  );
endinterface

// File: rtl/cfg_space_mf.sv
// -----------------------------------------------------------------------------
// cfg_space_mf
//   Multi-function PCIe Type-0 configuration space. Each function holds a
//   header (Command/Status, cache line size, BAR0, interrupt line) plus a
//   fully writable scratch region from DW16 upwards. Every accepted request
//   yields exactly one completion from a single-entry registered buffer.
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     bus                request/completion channel (slave modport)
//     err_master_abort   per-function pulse, sets Status bit 29
//     err_target_abort   per-function pulse, sets Status bit 28
//     cfg_mem_en         Command bit 1 per function
//     cfg_bus_master_en  Command bit 2 per function
// -----------------------------------------------------------------------------
module cfg_space_mf #(
  parameter int          NUM_FUNC       = 1,
  parameter int          NUM_DW         = 64,
  parameter logic [15:0] VENDOR_ID      = 16'h1234,
  parameter logic [15:0] DEVICE_ID      = 16'hABCD,
  parameter logic [23:0] CLASS_CODE     = 24'h010601,
  parameter logic [7:0]  REV_ID         = 8'h01,
  parameter int          BAR0_SIZE_LOG2 = 12
) (
  input  logic                clk,
  input  logic                rst,
  cfg_space_mf_if.slave       bus,
  input  logic [NUM_FUNC-1:0] err_master_abort,
  input  logic [NUM_FUNC-1:0] err_target_abort,
  output logic [NUM_FUNC-1:0] cfg_mem_en,
  output logic [NUM_FUNC-1:0] cfg_bus_master_en
);

  localparam int FW  = (NUM_FUNC > 1) ? $clog2(NUM_FUNC) : 1;
  localparam int SW  = NUM_DW - 16;               // scratch DWORDs per function
  localparam int SWA = (SW > 0) ? SW : 1;         // keep the array non-empty
  localparam int SAW = (SWA > 1) ? $clog2(SWA) : 1;
  localparam int BW  = 32 - BAR0_SIZE_LOG2;       // writable BAR0 address bits

  localparam logic [15:0] CMD_RW_MASK = 16'h0546; // bits 1, 2, 6, 8, 10
  localparam logic [7:0]  HDR_TYPE    = (NUM_FUNC > 1) ? 8'h80 : 8'h00;
  localparam logic [1:0]  ST_SC       = 2'b00;
  localparam logic [1:0]  ST_UR       = 2'b01;

  // Stored state. sts_q packs {bit29 master abort, bit28 target abort}.
  logic [15:0]   cmd_q  [NUM_FUNC];
  logic [15:0]   cmd_d  [NUM_FUNC];
  logic [1:0]    sts_q  [NUM_FUNC];
  logic [1:0]    sts_d  [NUM_FUNC];
  logic [7:0]    cls_q  [NUM_FUNC];
  logic [7:0]    cls_d  [NUM_FUNC];
  logic [BW-1:0] bar_q  [NUM_FUNC];
  logic [BW-1:0] bar_d  [NUM_FUNC];
  logic [7:0]    intl_q [NUM_FUNC];
  logic [7:0]    intl_d [NUM_FUNC];
  logic [31:0]   scr_q  [NUM_FUNC][SWA];

  logic          cpl_valid_q, cpl_valid_d;
  logic [31:0]   cpl_rdata_q, cpl_rdata_d;
  logic [1:0]    cpl_status_q, cpl_status_d;

  // Request decode
  logic          accept;
  logic          ur;
  logic          wr_en;
  logic [FW-1:0] fsel;
  logic [9:0]    addr;
  logic [SAW-1:0] scr_idx;
  logic [31:0]   bm;
  logic [31:0]   rd_val;
  logic [31:0]   scr_rd;
  logic          scr_we;
  logic [31:0]   scr_wd;
  logic [1:0]    sts_clr;

  assign bus.req_ready  = !rst && (!cpl_valid_q || bus.cpl_ready);
  assign bus.cpl_valid  = cpl_valid_q;
  assign bus.cpl_rdata  = cpl_rdata_q;
  assign bus.cpl_status = cpl_status_q;

  assign accept = bus.req_valid && bus.req_ready;
  assign addr   = bus.req_addr_dw;
  assign ur     = (32'(bus.req_func) >= NUM_FUNC) || (32'(addr) >= NUM_DW);
  // Out-of-range function numbers never index the arrays.
  assign fsel   = ur ? '0 : bus.req_func;
  assign wr_en  = accept && bus.req_wr && !ur;
  assign scr_idx = SAW'(addr - 10'd16);
  assign bm     = {{8{bus.req_be[3]}}, {8{bus.req_be[2]}},
                   {8{bus.req_be[1]}}, {8{bus.req_be[0]}}};

  for (genvar g = 0; g < NUM_FUNC; g++) begin : g_cmd_out
    assign cfg_mem_en[g]        = cmd_q[g][1];
    assign cfg_bus_master_en[g] = cmd_q[g][2];
  end

  // Read mux over the state as it stands before this cycle's update.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    rd_val = '0;
    scr_rd = scr_q[fsel][scr_idx];
    case (addr)
      10'd0:   rd_val = {DEVICE_ID, VENDOR_ID};
      10'd1:   rd_val = {2'b00, sts_q[fsel], 12'h000, cmd_q[fsel]};
      10'd2:   rd_val = {CLASS_CODE, REV_ID};
      10'd3:   rd_val = {8'h00, HDR_TYPE, 8'h00, cls_q[fsel]};
      10'd4:   rd_val = {bar_q[fsel], {BAR0_SIZE_LOG2{1'b0}}};
      10'd15:  rd_val = {24'h000000, intl_q[fsel]};
      default: if (addr >= 10'd16) rd_val = scr_rd;
    endcase
  end

  // Next-state for the header registers and the scratch write port.
  always_comb begin
    cmd_d   = cmd_q;
    cls_d   = cls_q;
    bar_d   = bar_q;
    intl_d  = intl_q;
    scr_we  = 1'b0;
    scr_wd  = (scr_rd & ~bm) | (bus.req_wdata & bm);
    sts_clr = 2'b00;
    if (wr_en) begin
      case (addr)
        10'd1: begin
          cmd_d[fsel] = (cmd_q[fsel] & ~(bm[15:0] & CMD_RW_MASK)) |
                        (bus.req_wdata[15:0] & bm[15:0] & CMD_RW_MASK);
          sts_clr     = bus.req_wdata[29:28] & bm[29:28];
        end
        10'd3:  if (bus.req_be[0]) cls_d[fsel]  = bus.req_wdata[7:0];
        10'd4:  bar_d[fsel] = (bar_q[fsel] & ~bm[31:BAR0_SIZE_LOG2]) |
                              (bus.req_wdata[31:BAR0_SIZE_LOG2] & bm[31:BAR0_SIZE_LOG2]);
        10'd15: if (bus.req_be[0]) intl_d[fsel] = bus.req_wdata[7:0];
        default: scr_we = (addr >= 10'd16);
      endcase
    end
    // Error pulses are OR-ed in after the clear, so a coincident set wins.
    for (int f = 0; f < NUM_FUNC; f++) begin
      sts_d[f] = (sts_q[f] & ~((fsel == FW'(f)) ? sts_clr : 2'b00)) |
                 {err_master_abort[f], err_target_abort[f]};
    end
  end

  // Completion buffer: load on accept, otherwise drain on cpl_ready.
  always_comb begin
    cpl_valid_d  = cpl_valid_q;
    cpl_rdata_d  = cpl_rdata_q;
    cpl_status_d = cpl_status_q;
    if (accept) begin
      cpl_valid_d  = 1'b1;
      cpl_rdata_d  = (bus.req_wr || ur) ? 32'h0 : rd_val;
      cpl_status_d = ur ? ST_UR : ST_SC;
    end else if (bus.cpl_ready) begin
      cpl_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: scratch is built from flops and cleared on reset because its reset value is architecturally visible.
      for (int f = 0; f < NUM_FUNC; f++) begin
        cmd_q[f]  <= '0;
        sts_q[f]  <= '0;
        cls_q[f]  <= '0;
        bar_q[f]  <= '0;
        intl_q[f] <= '0;
        for (int i = 0; i < SWA; i++) scr_q[f][i] <= '0;
      end
      cpl_valid_q  <= 1'b0;
      cpl_rdata_q  <= '0;
      cpl_status_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cmd_q  <= cmd_d;
      sts_q  <= sts_d;
      cls_q  <= cls_d;
      bar_q  <= bar_d;
      intl_q <= intl_d;
      if (scr_we) scr_q[fsel][scr_idx] <= scr_wd;
      cpl_valid_q  <= cpl_valid_d;
      cpl_rdata_q  <= cpl_rdata_d;
      cpl_status_q <= cpl_status_d;
    end
  end

endmodule

// File: tb/tb_cfg_space_mf.sv
// -----------------------------------------------------------------------------
// tb_cfg_space_mf
//   Directed bench for cfg_space_mf with three functions (so function 3 is
//   encodable and unsupported). The driver pushes the hand-computed completion
//   into a queue at acceptance; a monitor pops and compares whenever a
//   completion is consumed.
// -----------------------------------------------------------------------------
module tb_cfg_space_mf;

  localparam int NF = 3;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  status;
  } cpl_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] err_ma, err_ta;
  logic [NF-1:0] mem_en, bm_en;

  int   checks   = 0;
  int   failures = 0;
  int   cpl_seen = 0;
  cpl_t exp_q[$];

  always #5 clk = ~clk;

  cfg_space_mf_if #(.NUM_FUNC(NF)) bus ();

  cfg_space_mf #(.NUM_FUNC(NF), .NUM_DW(64), .BAR0_SIZE_LOG2(12)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .err_master_abort  (err_ma),
    .err_target_abort  (err_ta),
    .cfg_mem_en        (mem_en),
    .cfg_bus_master_en (bm_en)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a posedge. Holds the request until accepted, pushes the
  // expected completion and checks that cpl_valid rises the next cycle.
  task automatic issue(input logic wr, input logic [1:0] func, input logic [9:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rd, input logic [1:0] exp_st,
                       input logic [NF-1:0] ma, input logic [NF-1:0] ta);
    int n;
    cpl_t e;
    bus.req_valid   = 1'b1;
    bus.req_wr      = wr;
    bus.req_func    = func;
    bus.req_addr_dw = addr;
    bus.req_wdata   = wdata;
    bus.req_be      = be;
    err_ma          = ma;
    err_ta          = ta;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      err_ma = '0;
      err_ta = '0;
      return;
    end
    @(posedge clk);
    #1;
    e.rdata  = exp_rd;
    e.status = exp_st;
    exp_q.push_back(e);
    bus.req_valid = 1'b0;
    err_ma = '0;
    err_ta = '0;
    check("cpl_latency", 32'(bus.cpl_valid), 32'd1);
  endtask

  task automatic rd(input logic [1:0] func, input logic [9:0] addr,
                    input logic [31:0] exp_rd, input logic [1:0] exp_st);
    issue(1'b0, func, addr, 32'h0, 4'h0, exp_rd, exp_st, '0, '0);
  endtask

  task automatic wr(input logic [1:0] func, input logic [9:0] addr,
                    input logic [31:0] wdata, input logic [3:0] be, input logic [1:0] exp_st);
    issue(1'b1, func, addr, wdata, be, 32'h0, exp_st, '0, '0);
  endtask

  task automatic pulse(input logic [NF-1:0] ma, input logic [NF-1:0] ta);
    err_ma = ma;
    err_ta = ta;
    @(posedge clk);
    #1;
    err_ma = '0;
    err_ta = '0;
  endtask

  // Monitor: one comparison per consumed completion.
  always @(negedge clk) begin
    if (!rst && bus.cpl_valid && bus.cpl_ready) begin
      cpl_t e;
      if (exp_q.size() == 0) begin
        check("cpl_unexpected", 32'(bus.cpl_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        cpl_seen++;
        check($sformatf("cpl%0d_rdata", cpl_seen), bus.cpl_rdata, e.rdata);
        check($sformatf("cpl%0d_status", cpl_seen), 32'(bus.cpl_status), 32'(e.status));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    err_ma = '0;
    err_ta = '0;
    bus.req_valid = 1'b0;
    bus.req_wr = 1'b0;
    bus.req_func = '0;
    bus.req_addr_dw = '0;
    bus.req_wdata = '0;
    bus.req_be = '0;
    bus.cpl_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",  32'(bus.req_ready),  32'd0);
    check("rst_cpl_valid",  32'(bus.cpl_valid),  32'd0);
    check("rst_cpl_rdata",  bus.cpl_rdata,       32'd0);
    check("rst_cpl_status", 32'(bus.cpl_status), 32'd0);
    check("rst_mem_en",     32'(mem_en),         32'd0);
    check("rst_bm_en",      32'(bm_en),          32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Identity registers, back-to-back
    rd(2'd0, 10'd0, 32'hABCD1234, 2'b00);
    rd(2'd0, 10'd2, 32'h01060101, 2'b00);
    rd(2'd0, 10'd3, 32'h00800000, 2'b00);

    // BAR0 sizing
    wr(2'd0, 10'd4, 32'hFFFFFFFF, 4'hF, 2'b00);
    rd(2'd0, 10'd4, 32'hFFFFF000, 2'b00);
    wr(2'd0, 10'd4, 32'h12345678, 4'hF, 2'b00);
    rd(2'd0, 10'd4, 32'h12345000, 2'b00);

    // Command register and RO header
    wr(2'd0, 10'd1, 32'hFFFFFFFF, 4'hF, 2'b00);
    check("mem_en_f0", 32'(mem_en), 32'd1);
    check("bm_en_f0",  32'(bm_en),  32'd1);
    rd(2'd0, 10'd1, 32'h00000546, 2'b00);
    wr(2'd0, 10'd0, 32'h00000000, 4'hF, 2'b00);
    rd(2'd0, 10'd0, 32'hABCD1234, 2'b00);
    wr(2'd0, 10'd3, 32'hFFFFFFFF, 4'hF, 2'b00);
    rd(2'd0, 10'd3, 32'h008000FF, 2'b00);
    wr(2'd0, 10'd15, 32'hFFFFFFFF, 4'hF, 2'b00);
    rd(2'd0, 10'd15, 32'h000000FF, 2'b00);
    wr(2'd0, 10'd5, 32'hFFFFFFFF, 4'hF, 2'b00);
    rd(2'd0, 10'd5, 32'h00000000, 2'b00);

    // RW1C status bits
    pulse(3'b010, 3'b000);
    rd(2'd1, 10'd1, 32'h20000000, 2'b00);
    wr(2'd1, 10'd1, 32'h20000000, 4'b1000, 2'b00);
    rd(2'd1, 10'd1, 32'h00000000, 2'b00);
    issue(1'b1, 2'd1, 10'd1, 32'h20000000, 4'b1000, 32'h0, 2'b00, 3'b010, 3'b000);
    rd(2'd1, 10'd1, 32'h20000000, 2'b00);
    pulse(3'b000, 3'b100);
    rd(2'd2, 10'd1, 32'h10000000, 2'b00);
    issue(1'b0, 2'd2, 10'd1, 32'h0, 4'h0, 32'h10000000, 2'b00, 3'b100, 3'b000);
    rd(2'd2, 10'd1, 32'h30000000, 2'b00);

    // Unsupported requests
    rd(2'd3, 10'd0, 32'h0, 2'b01);
    rd(2'd0, 10'd64, 32'h0, 2'b01);
    wr(2'd3, 10'd20, 32'h55555555, 4'hF, 2'b01);
    rd(2'd0, 10'd20, 32'h0, 2'b00);
    rd(2'd1, 10'd20, 32'h0, 2'b00);

    // Scratch with partial byte enables and the top DWORD
    wr(2'd0, 10'd20, 32'hAABBCCDD, 4'b0101, 2'b00);
    rd(2'd0, 10'd20, 32'h00BB00DD, 2'b00);
    rd(2'd1, 10'd20, 32'h0, 2'b00);
    wr(2'd2, 10'd63, 32'hDEADBEEF, 4'hF, 2'b00);
    rd(2'd2, 10'd63, 32'hDEADBEEF, 2'b00);
    @(posedge clk);
    #1;

    // Backpressure: completion must hold for three cycles
    bus.cpl_ready = 1'b0;
    rd(2'd0, 10'd20, 32'h00BB00DD, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_req_ready",  32'(bus.req_ready),  32'd0);
      check("bp_cpl_valid",  32'(bus.cpl_valid),  32'd1);
      check("bp_cpl_rdata",  bus.cpl_rdata,       32'h00BB00DD);
      check("bp_cpl_status", 32'(bus.cpl_status), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.cpl_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset with a completion pending
    bus.cpl_ready = 1'b0;
    rd(2'd0, 10'd0, 32'hABCD1234, 2'b00);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_cpl_valid", 32'(bus.cpl_valid), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    check("midrst_mem_en",    32'(mem_en),        32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.cpl_ready = 1'b1;
    rd(2'd0, 10'd20, 32'h0, 2'b00);
    rd(2'd0, 10'd4,  32'h0, 2'b00);
    rd(2'd0, 10'd1,  32'h0, 2'b00);
    rd(2'd1, 10'd1,  32'h0, 2'b00);
    rd(2'd0, 10'd3,  32'h00800000, 2'b00);
    rd(2'd2, 10'd63, 32'h0, 2'b00);

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
